// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares the single data-memory port between the pipeline MEM stage (CPU
// port) and a word-wide DMA/loader port. The CPU wins by default; a
// starvation counter forces a DMA grant after STARVE_LIMIT consecutive
// denials, and dma_lock lets the DMA keep the port for up to BURST_MAX
// back-to-back grants. Grants and memory commands are combinational in the
// request cycle; read data is registered and returned to the owner of the
// load one cycle later with a single-cycle valid pulse.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata/funct3  CPU access (byte address, size in funct3)
//   cpu_gnt, cpu_stall          CPU accepted / CPU must freeze this cycle
//   cpu_rvalid, cpu_rdata       registered CPU load return
//   dma_req/we/waddr/wdata/lock DMA word access (word address), burst hold
//   dma_gnt                     DMA accepted this cycle
//   dma_rvalid, dma_rdata       registered DMA read return
//   mem_read/write/a/wd/funct3  command to the data memory
//   mem_rd                      read data from the data memory
module dmem_arbiter #(
  parameter int DM_ADDRESS   = 9,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int BURST_MAX    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [2:0]            cpu_funct3,
  output logic                  cpu_gnt,
  output logic                  cpu_stall,
  output logic                  cpu_rvalid,
  output logic [DATA_W-1:0]     cpu_rdata,
  input  logic                  dma_req,
  input  logic                  dma_we,
  input  logic [DM_ADDRESS-3:0] dma_waddr,
  input  logic [DATA_W-1:0]     dma_wdata,
  input  logic                  dma_lock,
  output logic                  dma_gnt,
  output logic                  dma_rvalid,
  output logic [DATA_W-1:0]     dma_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [DM_ADDRESS-1:0] mem_a,
  output logic [DATA_W-1:0]     mem_wd,
  output logic [2:0]            mem_funct3,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);
  localparam logic [3:0] BURST_LIM  = 4'(BURST_MAX);

  // The state records who owned the previous grant.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CPU_OWN   = 2'd1,
    DMA_OWN   = 2'd2,
    DMA_BURST = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic [3:0] burst_cnt, burst_nxt;
  logic       burst_hold;
  logic       dma_win;
  logic       cpu_win;

  // Arbitration. Gating with rst_n keeps every grant low while in reset,
  // which in turn silences the memory command outputs.
  always_comb begin
    burst_hold = (state == DMA_BURST) && dma_lock && (burst_cnt < BURST_LIM);
    dma_win    = rst_n && dma_req &&
                 (!cpu_req || (starve_cnt == STARVE_LIM) || burst_hold);
    cpu_win    = rst_n && cpu_req && !dma_win;
  end

  // State register together with the starvation and burst counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      burst_cnt  <= 4'd0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      burst_cnt  <= burst_nxt;
    end
  end

  // Next ownership and counter values. A DMA grant that arrives after an
  // exhausted burst (or from any non-burst state) restarts the burst at 1.
  always_comb begin
    state_nxt  = IDLE;
    starve_nxt = starve_cnt;
    burst_nxt  = 4'd0;

    if (dma_win) begin
      state_nxt = dma_lock ? DMA_BURST : DMA_OWN;
      if ((state == DMA_BURST) && (burst_cnt < BURST_LIM))
        burst_nxt = burst_cnt + 4'd1;
      else
        burst_nxt = 4'd1;
    end else if (cpu_win) begin
      state_nxt = CPU_OWN;
    end

    if (!dma_req || dma_win)
      starve_nxt = 4'd0;
    else if (starve_cnt < STARVE_LIM)
      starve_nxt = starve_cnt + 4'd1;
  end

  // Grants, stall and the memory command driven from the winner.
  always_comb begin
    cpu_gnt    = cpu_win;
    dma_gnt    = dma_win;
    cpu_stall  = cpu_req && !cpu_win;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_a      = '0;
    mem_wd     = '0;
    mem_funct3 = 3'b000;

    if (dma_win) begin
      mem_read   = !dma_we;
      mem_write  = dma_we;
      mem_a      = {dma_waddr, 2'b00};
      mem_wd     = dma_wdata;
      mem_funct3 = 3'b010;
    end else if (cpu_win) begin
      mem_read   = !cpu_we;
      mem_write  = cpu_we;
      mem_a      = cpu_addr;
      mem_wd     = cpu_wdata;
      mem_funct3 = cpu_funct3;
    end
  end

  // Read return: capture the memory data at the edge that ends the load
  // cycle and pulse the owner's valid for the following cycle. Reset drops
  // any load that was still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      dma_rvalid <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      cpu_rvalid <= cpu_win && !cpu_we;
      dma_rvalid <= dma_win && !dma_we;
      if (cpu_win && !cpu_we)
        cpu_rdata <= mem_rd;
      if (dma_win && !dma_we)
        dma_rdata <= mem_rd;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with a small byte-addressed data memory
// (asynchronous read with load sizing, synchronous write with store sizing)
// hanging off the mem_* port. Expected grant patterns and data values are
// worked out by hand for STARVE_LIMIT=4 and BURST_MAX=8.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [8:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic [2:0]  cpu_funct3;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dma_req, dma_we, dma_lock;
  logic [6:0]  dma_waddr;
  logic [31:0] dma_wdata;
  logic        dma_gnt, dma_rvalid;
  logic [31:0] dma_rdata;
  logic        mem_read, mem_write;
  logic [8:0]  mem_a;
  logic [31:0] mem_wd;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_rd;

  int vecCount  = 0;
  int failCount = 0;

  dmem_arbiter #(
    .DM_ADDRESS(9), .DATA_W(32), .STARVE_LIMIT(4), .BURST_MAX(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_waddr(dma_waddr),
    .dma_wdata(dma_wdata), .dma_lock(dma_lock),
    .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a),
    .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Data memory; word 0x010 starts out holding 0x12345678.
  logic [7:0] memBytes [0:511] = '{16: 8'h78, 17: 8'h56, 18: 8'h34,
                                   19: 8'h12, default: 8'h00};

  // Asynchronous read, sized and sign-extended by funct3.
  always_comb begin
    logic [7:0] b0, b1, b2, b3;
    b0 = memBytes[mem_a];
    b1 = memBytes[mem_a + 9'd1];
    b2 = memBytes[mem_a + 9'd2];
    b3 = memBytes[mem_a + 9'd3];
    case (mem_funct3)
      3'b000:  mem_rd = {{24{b0[7]}}, b0};
      3'b001:  mem_rd = {{16{b1[7]}}, b1, b0};
      3'b100:  mem_rd = {24'd0, b0};
      3'b101:  mem_rd = {16'd0, b1, b0};
      default: mem_rd = {b3, b2, b1, b0};
    endcase
  end

  // Synchronous write, sized by funct3.
  always @(posedge clk) begin
    if (mem_write) begin
      memBytes[mem_a] <= mem_wd[7:0];
      if (mem_funct3 != 3'b000)
        memBytes[mem_a + 9'd1] <= mem_wd[15:8];
      if (mem_funct3 == 3'b010) begin
        memBytes[mem_a + 9'd2] <= mem_wd[23:16];
        memBytes[mem_a + 9'd3] <= mem_wd[31:24];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vecCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cReq, input logic cWe,
                               input logic [8:0] cAddr, input logic [31:0] cWdata,
                               input logic [2:0] cF3, input logic dReq,
                               input logic dWe, input logic [6:0] dWaddr,
                               input logic [31:0] dWdata, input logic dLock);
    cpu_req    = cReq;
    cpu_we     = cWe;
    cpu_addr   = cAddr;
    cpu_wdata  = cWdata;
    cpu_funct3 = cF3;
    dma_req    = dReq;
    dma_we     = dWe;
    dma_waddr  = dWaddr;
    dma_wdata  = dWdata;
    dma_lock   = dLock;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic expDma, prevCpu, prevDma;
    int   dmaIdx;

    // Reset with both requesters active: nothing may be granted.
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 1'b1, 1'b0, 7'h05, 32'h0, 1'b0);
    #2;
    checkOutput("rst_cpu_gnt",   32'(cpu_gnt),   0);
    checkOutput("rst_dma_gnt",   32'(dma_gnt),   0);
    checkOutput("rst_mem_read",  32'(mem_read),  0);
    checkOutput("rst_mem_write", 32'(mem_write), 0);
    tick();
    tick();
    checkOutput("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    checkOutput("rst_dma_rvalid", 32'(dma_rvalid), 0);
    checkOutput("rst_cpu_rdata",  cpu_rdata, 32'h0);

    // Release reset during a CPU load of 0x010.
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 9'h010, 32'h0, 3'b010, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    checkOutput("first_cpu_gnt",  32'(cpu_gnt),  1);
    checkOutput("first_mem_read", 32'(mem_read), 1);
    checkOutput("first_mem_a",    32'(mem_a),    32'h010);
    tick();
    checkOutput("first_rvalid", 32'(cpu_rvalid), 1);
    checkOutput("first_rdata",  cpu_rdata, 32'h12345678);
    idleInputs();
    tick();
    checkOutput("first_rvalid_pulse", 32'(cpu_rvalid), 0);

    // CPU only: store a word, then load it back.
    applyStimulus(1'b1, 1'b1, 9'h024, 32'hDEADBEEF, 3'b010, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
    #1;
    checkOutput("st_cpu_gnt",   32'(cpu_gnt),   1);
    checkOutput("st_mem_write", 32'(mem_write), 1);
    checkOutput("st_mem_read",  32'(mem_read),  0);
    checkOutput("st_mem_wd",    mem_wd, 32'hDEADBEEF);
    tick();
    checkOutput("st_no_rvalid", 32'(cpu_rvalid), 0);
    applyStimulus(1'b1, 1'b0, 9'h024, 32'h0, 3'b010, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
    #1;
    checkOutput("ld_cpu_gnt",    32'(cpu_gnt),    1);
    checkOutput("ld_mem_a",      32'(mem_a),      32'h024);
    checkOutput("ld_mem_funct3", 32'(mem_funct3), 32'h2);
    checkOutput("ld_cpu_stall",  32'(cpu_stall),  0);
    tick();
    checkOutput("ld_rvalid", 32'(cpu_rvalid), 1);
    checkOutput("ld_rdata",  cpu_rdata, 32'hDEADBEEF);
    idleInputs();
    tick();
    checkOutput("ld_rvalid_pulse", 32'(cpu_rvalid), 0);
    checkOutput("ld_rdata_hold",   cpu_rdata, 32'hDEADBEEF);

    // Contention without lock: CPU four cycles, DMA on the fifth, repeating.
    applyStimulus(1'b1, 1'b0, 9'h024, 32'h0, 3'b010, 1'b1, 1'b0, 7'h04, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      expDma = ((i % 5) == 4);
      #1;
      checkOutput($sformatf("cont_cpu_gnt[%0d]", i),   32'(cpu_gnt),   32'(!expDma));
      checkOutput($sformatf("cont_dma_gnt[%0d]", i),   32'(dma_gnt),   32'(expDma));
      checkOutput($sformatf("cont_cpu_stall[%0d]", i), 32'(cpu_stall), 32'(expDma));
      tick();
      checkOutput($sformatf("cont_cpu_rvalid[%0d]", i), 32'(cpu_rvalid), 32'(!expDma));
      checkOutput($sformatf("cont_dma_rvalid[%0d]", i), 32'(dma_rvalid), 32'(expDma));
      if (expDma)
        checkOutput($sformatf("cont_dma_rdata[%0d]", i), dma_rdata, 32'h12345678);
    end
    idleInputs();
    tick();

    // Locked DMA writes of words 0..9 against a CPU that never lets go.
    dmaIdx  = 0;
    prevCpu = 1'b0;
    prevDma = 1'b0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 1'b0, 9'h024, 32'h0, 3'b010, (dmaIdx < 10), 1'b1,
                    7'(dmaIdx), 32'h100 + 32'(dmaIdx), 1'b1);
      expDma = ((i >= 4) && (i <= 11)) || (i == 16) || (i == 17);
      #1;
      checkOutput($sformatf("burst_dma_gnt[%0d]", i), 32'(dma_gnt), 32'(expDma));
      checkOutput($sformatf("burst_cpu_gnt[%0d]", i), 32'(cpu_gnt), 32'(!expDma));
      if (expDma) begin
        checkOutput($sformatf("burst_mem_a[%0d]", i), 32'(mem_a), 32'(dmaIdx * 4));
        dmaIdx++;
      end
      tick();
    end
    idleInputs();
    tick();

    // Read the DMA-written words back with back-to-back CPU loads.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 9'(i * 4), 32'h0, 3'b010, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
      tick();
      checkOutput($sformatf("rb_rvalid[%0d]", i), 32'(cpu_rvalid), 1);
      checkOutput($sformatf("rb_rdata[%0d]", i),  cpu_rdata, 32'h100 + 32'(i));
    end
    idleInputs();
    tick();

    // DMA word write, then a CPU signed byte load of the same location.
    applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b1, 1'b1, 7'h03, 32'h000000F0, 1'b0);
    #1;
    checkOutput("dw_dma_gnt",    32'(dma_gnt),    1);
    checkOutput("dw_mem_a",      32'(mem_a),      32'h00C);
    checkOutput("dw_mem_funct3", 32'(mem_funct3), 32'h2);
    checkOutput("dw_mem_wd",     mem_wd, 32'h000000F0);
    tick();
    checkOutput("dw_no_rvalid", 32'(dma_rvalid), 0);
    applyStimulus(1'b1, 1'b0, 9'h00C, 32'h0, 3'b000, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0);
    tick();
    checkOutput("lb_rvalid", 32'(cpu_rvalid), 1);
    checkOutput("lb_rdata",  cpu_rdata, 32'hFFFFFFF0);
    idleInputs();
    tick();

    // Build up starvation, then reset while a DMA read is in flight.
    applyStimulus(1'b1, 1'b0, 9'h024, 32'h0, 3'b010, 1'b1, 1'b0, 7'h01, 32'h0, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 9'h000, 32'h0, 3'b000, 1'b1, 1'b0, 7'h01, 32'h0, 1'b1);
    #1;
    checkOutput("mr_dma_gnt", 32'(dma_gnt), 1);
    #6;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_dma_gnt_rst",  32'(dma_gnt),  0);
    checkOutput("mr_mem_read_rst", 32'(mem_read), 0);
    tick();
    checkOutput("mr_dma_rvalid", 32'(dma_rvalid), 0);
    checkOutput("mr_starve_cnt", 32'(dut.starve_cnt), 0);
    checkOutput("mr_burst_cnt",  32'(dut.burst_cnt),  0);
    checkOutput("mr_state",      32'(dut.state),      0);
    idleInputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkOutput("mr_dma_rvalid_rel", 32'(dma_rvalid), 0);
    checkOutput("mr_dma_rdata_rel",  dma_rdata, 32'h0);
    applyStimulus(1'b1, 1'b0, 9'h024, 32'h0, 3'b010, 1'b1, 1'b0, 7'h01, 32'h0, 1'b0);
    #1;
    checkOutput("mr_cpu_wins", 32'(cpu_gnt), 1);
    checkOutput("mr_dma_lose", 32'(dma_gnt), 0);
    tick();
    idleInputs();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data memory port between two requesters: the pipeline MEM stage (CPU port) and a word-wide DMA/loader port.
- CPU has default priority. A starvation counter guarantees DMA progress, and a bounded lock lets DMA run short bursts.
- Drives the memory's MemRead/MemWrite/a/wd/Funct3 inputs and takes its read data.
- Registers returned read data and routes it to the owning requester with a valid pulse.

Parameters:
- DM_ADDRESS, 9, byte address width of data memory.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive cycles a pending DMA request may be denied before DMA is forced to win (1..15).
- BURST_MAX, 8, max consecutive DMA grants while dma_lock is held (1..15).

Ports:
- clk  in  1  system clock, rising-edge logic.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU access request; valid for this cycle only, re-evaluated each cycle.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  DM_ADDRESS  byte address.
- cpu_wdata  in  DATA_W  store data.
- cpu_funct3  in  3  load/store size, passed to memory unchanged.
- cpu_gnt  out  1  access accepted this cycle.
- cpu_stall  out  1  cpu_req & ~cpu_gnt; freezes pipeline.
- cpu_rvalid  out  1  cpu_rdata valid (one cycle after a granted load).
- cpu_rdata  out  DATA_W  registered load data.
- dma_req  in  1  DMA request; held until dma_gnt.
- dma_we  in  1  1 = write word, 0 = read word.
- dma_waddr  in  DM_ADDRESS-2  word address.
- dma_wdata  in  DATA_W  write data.
- dma_lock  in  1  request back-to-back grants.
- dma_gnt  out  1  access accepted this cycle.
- dma_rvalid  out  1  dma_rdata valid.
- dma_rdata  out  DATA_W  registered read data.
- mem_read  out  1  to memory MemRead.
- mem_write  out  1  to memory MemWrite.
- mem_a  out  DM_ADDRESS  to memory address.
- mem_wd  out  DATA_W  to memory write data.
- mem_funct3  out  3  to memory Funct3.
- mem_rd  in  DATA_W  from memory read data.

Behaviour:
- States: IDLE, CPU_OWN, DMA_OWN, DMA_BURST. The state is the owner of the previous grant. IDLE = no grant last cycle.
- Grant is combinational in the request cycle. At most one gnt per cycle.
  - DMA wins if: dma_req & (~cpu_req | starve_cnt == STARVE_LIMIT | (state == DMA_BURST & dma_lock & burst_cnt < BURST_MAX)).
  - Otherwise CPU wins if cpu_req.
- Memory command outputs are combinational from the winner.
  - No winner: mem_read = mem_write = 0; mem_a, mem_wd, mem_funct3 hold 0.
  - CPU winner: fields passed through.
  - DMA winner: mem_a = {dma_waddr, 2'b00}, mem_funct3 = 3'b010.
- starve_cnt (4 bit):
  - Increments when dma_req is denied; saturates at STARVE_LIMIT.
  - Clears on dma_gnt, or when dma_req is low.
- burst_cnt (4 bit):
  - Set to 1 on a DMA grant from a non-burst state.
  - Increments on each further DMA grant in DMA_BURST.
  - Clears when ownership leaves DMA.
- Transitions:
  - Any DMA grant with dma_lock → DMA_BURST.
  - DMA grant without dma_lock → DMA_OWN.
  - CPU grant → CPU_OWN.
  - No grant → IDLE.
  - DMA_BURST & burst_cnt == BURST_MAX: DMA loses priority; CPU wins if requesting, else DMA may still win as sole requester, but burst_cnt restarts at 1.
- Read return:
  - A granted load issued in cycle N registers mem_rd at rising edge N+1.
  - The owner's rvalid is high for exactly cycle N+1.
  - The rdata register holds its value until the next load return.
  - Stores produce no rvalid.
- Back-to-back loads: each returns one cycle after issue, so throughput is 1/cycle.
- Simultaneous requests, none forced: CPU wins, dma_gnt = 0, starve_cnt++.
- Reset (async, any cycle):
  - State → IDLE; starve_cnt and burst_cnt → 0.
  - cpu_rvalid, dma_rvalid → 0; cpu_rdata, dma_rdata → 0.
  - Any in-flight read return is discarded; no rvalid after reset release.
  - Combinational gnt and mem_* outputs are forced to 0 while rst_n = 0.

Test Plan:
- Reset: rst_n=0 with both requests high → all gnt, rvalid and mem_read/mem_write = 0. After release, first read of address 0x010 returns the memory word at cycle+1, cpu_rvalid=1 for one cycle.
- CPU only: cpu load addr 0x024 funct3=010 → cpu_gnt=1, mem_a=0x024, cpu_stall=0. Next cycle cpu_rvalid=1, cpu_rdata = stored word 0xDEADBEEF.
- Contention, STARVE_LIMIT=4: cpu_req and dma_req held high → CPU granted 4 cycles, DMA granted 5th cycle (cpu_stall=1 that cycle), pattern repeats.
- DMA burst, BURST_MAX=8: dma_lock=1, dma_waddr 0..9 writes 0x100+i, cpu_req high → 8 consecutive dma_gnt, then CPU granted. Memory words 0..7 hold 0x100..0x107.
- DMA word write then CPU byte read: dma write waddr 3, data 0x000000F0 → mem_a=0x00C, mem_funct3=010. CPU LB at 0x00C → cpu_rdata=0xFFFFFFF0.
- Reset mid-read: grant a DMA read, then drop rst_n at the next rising-edge setup → dma_rvalid stays 0, counters 0, state IDLE.
